// File: rtl/vga_vert_timing.sv
// rtl/vga_vert_timing.sv - parametrised VGA vertical line counter with sync, text-row and blink decode
module vga_vert_timing #(
   parameter int V_VISIBLE    = 480,
   parameter int V_FRONT      = 10,
   parameter int V_SYNC       = 2,
   parameter int V_BACK       = 33,
   parameter int V_W          = 10,
   parameter bit SYNC_POL     = 1'b0,
   parameter int CHAR_H       = 16,
   parameter int ROW_W        = 5,
   parameter int SL_W         = 4,
   parameter int FC_W         = 8,
   parameter int BLINK_FRAMES = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   output logic [V_W-1:0]   Q,
   output logic             VSYNC,
   output logic             VACTIVE,
   output logic [ROW_W-1:0] ROW,
   output logic [SL_W-1:0]  SCANLINE,
   output logic             FRAME_START,
   output logic [FC_W-1:0]  FRAME_CNT,
   output logic             BLINK
);

   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   // Blink counter needs at least one bit even when BLINK_FRAMES is 1.
   localparam int BC_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   // Line-number boundaries held as 32-bit values so the sync window end
   // may reach 2^V_W without truncation.
   localparam logic [31:0]      LP_VIS      = 32'(V_VISIBLE);
   localparam logic [31:0]      LP_SYNC_BEG = 32'(V_VISIBLE + V_FRONT);
   localparam logic [31:0]      LP_SYNC_END = 32'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic [V_W-1:0]   LP_Q_LAST   = V_W'(V_TOTAL - 1);
   localparam logic [SL_W-1:0]  LP_SL_LAST  = SL_W'(CHAR_H - 1);
   localparam logic [BC_W-1:0]  LP_BC_LAST  = BC_W'(BLINK_FRAMES - 1);

   logic [V_W-1:0]   r_q;
   logic [ROW_W-1:0] r_row;
   logic [SL_W-1:0]  r_sl;
   logic             r_frame_start;
   logic [FC_W-1:0]  r_frame_cnt;
   logic [BC_W-1:0]  r_blink_cnt;
   logic             r_blink;

   logic             w_wrap;
   logic [V_W-1:0]   w_q_next;
   logic [ROW_W-1:0] w_row_next;
   logic [SL_W-1:0]  w_sl_next;
   logic [31:0]      w_q32;
   logic [31:0]      w_q_next32;
   logic             w_in_sync;

   // Next line number and the row/scanline that will describe it.
   always_comb begin
      w_wrap     = (r_q == LP_Q_LAST);
      w_q_next   = w_wrap ? '0 : (r_q + V_W'(1));
      w_q_next32 = 32'(w_q_next);
      w_row_next = '0;
      w_sl_next  = '0;
      if (w_q_next32 == 32'd0) begin
         w_row_next = '0;
         w_sl_next  = '0;
      end else if (w_q_next32 < LP_VIS) begin
         if (r_sl == LP_SL_LAST) begin
            w_sl_next  = '0;
            w_row_next = r_row + ROW_W'(1);
         end else begin
            w_sl_next  = r_sl + SL_W'(1);
            w_row_next = r_row;
         end
      end
   end

   // Line counter, text indices and per-frame state, advanced only on EN.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_q           <= '0;
         r_row         <= '0;
         r_sl          <= '0;
         r_frame_start <= 1'b0;
         r_frame_cnt   <= '0;
         r_blink_cnt   <= '0;
         r_blink       <= 1'b0;
      end else if (EN) begin
         r_q           <= w_q_next;
         r_row         <= w_row_next;
         r_sl          <= w_sl_next;
         r_frame_start <= w_wrap;
         if (w_wrap) begin
            r_frame_cnt <= r_frame_cnt + FC_W'(1);
            if (r_blink_cnt == LP_BC_LAST) begin
               r_blink_cnt <= '0;
               r_blink     <= ~r_blink;
            end else begin
               r_blink_cnt <= r_blink_cnt + BC_W'(1);
            end
         end
      end else begin
         r_frame_start <= 1'b0;
      end
   end

   // Zero-latency decodes of the registered line; sync forced inactive in reset.
   always_comb begin
      w_q32     = 32'(r_q);
      w_in_sync = (w_q32 >= LP_SYNC_BEG) && (w_q32 < LP_SYNC_END);
      VACTIVE   = (w_q32 < LP_VIS);
      if (RST) begin
         VSYNC = ~SYNC_POL;
      end else begin
         VSYNC = w_in_sync ? SYNC_POL : ~SYNC_POL;
      end
   end

   assign Q           = r_q;
   assign ROW         = r_row;
   assign SCANLINE    = r_sl;
   assign FRAME_START = r_frame_start;
   assign FRAME_CNT   = r_frame_cnt;
   assign BLINK       = r_blink;

endmodule

// File: doc/vga_vert_timing.md
Name: vga_vert_timing

Overview:
Parametrised vertical timing generator for the VGA text-mode pipeline. It is the successor to the fixed 525-line vertical counter. It advances one line per line-done pulse from the horizontal counter and decodes vertical sync and active video. It also supplies the text-row and in-character scanline indices used by glyph fetch, plus a frame counter and cursor-blink flag. It is fully synchronous to the pixel clock; EN is a clock enable, not a clock.

Parameters:
V_VISIBLE, 480, number of visible lines
V_FRONT, 10, front-porch lines
V_SYNC, 2, sync-pulse lines
V_BACK, 33, back-porch lines
V_W, 10, width of Q; must satisfy 2^V_W >= V_TOTAL, where V_TOTAL = sum of the four line-count parameters
SYNC_POL, 0, VSYNC level during the sync pulse (0 = active-low)
CHAR_H, 16, scanlines per character row, >= 1
ROW_W, 5, width of ROW; must hold ceil(V_VISIBLE/CHAR_H)-1
SL_W, 4, width of SCANLINE; must hold CHAR_H-1
FC_W, 8, width of FRAME_CNT
BLINK_FRAMES, 16, frames per BLINK half-period, >= 1

Ports:
CLK  in  1  pixel clock; all state updates on its rising edge
RST  in  1  reset, synchronous, active-high
EN  in  1  line-advance enable; one-cycle pulse from the horizontal counter terminal count
Q  out  V_W  current line number, 0..V_TOTAL-1
VSYNC  out  1  vertical sync
VACTIVE  out  1  high while Q < V_VISIBLE
ROW  out  ROW_W  text row of the current line
SCANLINE  out  SL_W  scanline within the character row
FRAME_START  out  1  one-cycle pulse on the first cycle of line 0
FRAME_CNT  out  FC_W  completed-frame counter, wraps modulo 2^FC_W
BLINK  out  1  cursor blink phase

Behaviour:
- Reset values: Q=0, ROW=0, SCANLINE=0, FRAME_CNT=0, BLINK=0, FRAME_START=0, internal blink counter=0.
- RST has priority over EN. Reset mid-frame forces all reset values on the next edge and discards any pending pulse.
- EN=0: all state holds and FRAME_START=0.
- EN=1 and Q < V_TOTAL-1: Q <= Q+1.
- EN=1 and Q = V_TOTAL-1: Q <= 0 (wrap event).
- Line-index rules, evaluated against the next value of Q:
  - Next Q = 0: ROW <= 0, SCANLINE <= 0.
  - Next Q in 1..V_VISIBLE-1: if SCANLINE = CHAR_H-1, then SCANLINE <= 0 and ROW <= ROW+1; otherwise SCANLINE <= SCANLINE+1.
  - Next Q >= V_VISIBLE: ROW <= 0, SCANLINE <= 0 (held through blanking).
  - ROW and SCANLINE therefore always describe the line currently on Q.
  - A partial last row is permitted when V_VISIBLE is not a multiple of CHAR_H.
- VACTIVE and VSYNC are combinational decodes of the registered Q, with zero latency relative to Q.
  - VSYNC = SYNC_POL when V_VISIBLE+V_FRONT <= Q < V_VISIBLE+V_FRONT+V_SYNC; otherwise VSYNC = ~SYNC_POL.
  - VSYNC is at the inactive level during reset.
- Wrap event:
  - FRAME_START is a registered pulse, high for exactly the one cycle after the wrapping edge, coincident with the first cycle of Q=0.
  - FRAME_CNT increments on the same edge and wraps from 2^FC_W-1 to 0.
  - Blink counter increments on the same edge. When it reaches BLINK_FRAMES-1 it clears to 0 and BLINK toggles.
- EN held high continuously is legal: one line per clock, used for accelerated simulation.
- Q never exceeds V_TOTAL-1 under any sequence of inputs.

Test Plan:
Bench parameters: V_VISIBLE=4, V_FRONT=1, V_SYNC=2, V_BACK=1 (V_TOTAL=8), V_W=3, CHAR_H=2, ROW_W=1, SL_W=1, BLINK_FRAMES=2, FC_W=2, SYNC_POL=0.
1. Reset, then EN=1 continuously for 8 cycles -> Q=0,1..7,0; VACTIVE high for Q=0..3; VSYNC low only for Q=5,6; FRAME_START high exactly on the cycle Q returns to 0; FRAME_CNT=1.
2. Same run -> (ROW,SCANLINE) = (0,0),(0,1),(1,0),(1,1) for Q=0..3, then (0,0) for Q=4..7.
3. EN pulsed once every 5 cycles -> Q changes only on the edge after each pulse; FRAME_START width is exactly 1 cycle; FRAME_START is never repeated while Q stays at 0.
4. Run 8 frames -> BLINK toggles after frames 2, 4, 6 and 8 (pattern 0,0,1,1,0,0,1,1,0); FRAME_CNT sequence 1,2,3,0,1,2,3,0.
5. RST asserted at Q=5 together with EN=1 -> next cycle Q=0, VSYNC=1, FRAME_START=0, FRAME_CNT=0, BLINK=0.
6. EN=1 while Q=7, with RST low -> Q=0, FRAME_START=1, ROW=0, SCANLINE=0; no out-of-range Q is ever observed.
